// File: rtl/wb_sched.sv
// wb_sched: shares the regfile write port between execute, divider and accelerator,
// and tracks the pending long-latency destinations on a two-entry scoreboard.
module wb_sched #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_reg1_raddr_i,
  input  logic [4:0]  id_reg2_raddr_i,
  input  logic        id_reg_we_i,
  input  logic [4:0]  id_reg_waddr_i,
  input  logic        id_long_i,
  input  logic        id_long_unit_i,
  input  logic        ex_jump_flag_i,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        div_valid_i,
  input  logic [31:0] div_wdata_i,
  output logic        div_ack_o,
  input  logic        acc_valid_i,
  input  logic [31:0] acc_wdata_i,
  output logic        acc_ack_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        hold_o,
  output logic        err_o
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [1:0] sb_v, uv, elig, gnt, match, set;
  logic [4:0] sb_rd [2];
  logic [3:0] cnt [2];
  logic       rr_acc, err, slot_free, hazard, starve, hold;
  logic [4:0] sel_rd;
  always_comb begin
    uv = {acc_valid_i, div_valid_i};
    slot_free = ~(ex_we_i & (ex_waddr_i != 5'd0));
    elig = uv & sb_v;
    gnt[0] = slot_free & elig[0] & (~elig[1] | rr_acc);
    gnt[1] = slot_free & elig[1] & (~elig[0] | ~rr_acc);
    for (int u = 0; u < 2; u++)
      match[u] = sb_v[u] & (sb_rd[u] != 5'd0) &
                 ((sb_rd[u] == id_reg1_raddr_i) | (sb_rd[u] == id_reg2_raddr_i) |
                  (id_reg_we_i & (sb_rd[u] == id_reg_waddr_i)));
    hazard = id_valid_i & ((|match) | (id_long_i & sb_v[id_long_unit_i]));
    starve = (cnt[0] >= LIM) | (cnt[1] >= LIM);
    hold = hazard | starve;
    set = {2{id_valid_i & id_long_i & ~hold & ~ex_jump_flag_i}} & {id_long_unit_i, ~id_long_unit_i};
    sel_rd = gnt[1] ? sb_rd[1] : sb_rd[0];
  end
  // combinational outputs are forced low while reset is asserted
  assign reg_we_o    = rst & (~slot_free | ((|gnt) & (sel_rd != 5'd0)));
  assign reg_waddr_o = ~rst ? 5'd0 : ~slot_free ? ex_waddr_i : (|gnt) ? sel_rd : 5'd0;
  assign reg_wdata_o = ~rst ? 32'd0 : ~slot_free ? ex_wdata_i :
                       gnt[1] ? acc_wdata_i : gnt[0] ? div_wdata_i : 32'd0;
  assign div_ack_o   = rst & gnt[0];
  assign acc_ack_o   = rst & gnt[1];
  assign hold_o      = rst & hold;
  assign err_o       = err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v     <= '0;
      sb_rd[0] <= '0;
      sb_rd[1] <= '0;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
      rr_acc   <= 1'b1;
      err      <= 1'b0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        sb_v[u] <= set[u] | (sb_v[u] & ~gnt[u]);
        if (set[u]) sb_rd[u] <= id_reg_waddr_i;
        cnt[u] <= (elig[u] & ~gnt[u]) ? ((cnt[u] == 4'd15) ? 4'd15 : cnt[u] + 4'd1) : 4'd0;
      end
      rr_acc <= gnt[1] ? 1'b1 : gnt[0] ? 1'b0 : rr_acc;
      err    <= err | (|(uv & ~sb_v));
    end
  end
endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed vector table for wb_sched plus hand sequences for reset and starvation.
module tb_wb_sched;
  logic clk = 1'b0, rst;
  logic id_valid_i, id_reg_we_i, id_long_i, id_long_unit_i, ex_jump_flag_i, ex_we_i;
  logic [4:0] id_reg1_raddr_i, id_reg2_raddr_i, id_reg_waddr_i, ex_waddr_i;
  logic [31:0] ex_wdata_i, div_wdata_i, acc_wdata_i;
  logic div_valid_i, acc_valid_i;
  logic div_ack_o, acc_ack_o, reg_we_o, hold_o, err_o;
  logic [4:0] reg_waddr_o;
  logic [31:0] reg_wdata_o;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  wb_sched #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_reg1_raddr_i(id_reg1_raddr_i), .id_reg2_raddr_i(id_reg2_raddr_i),
    .id_reg_we_i(id_reg_we_i), .id_reg_waddr_i(id_reg_waddr_i), .id_long_i(id_long_i),
    .id_long_unit_i(id_long_unit_i), .ex_jump_flag_i(ex_jump_flag_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .div_valid_i(div_valid_i), .div_wdata_i(div_wdata_i), .div_ack_o(div_ack_o),
    .acc_valid_i(acc_valid_i), .acc_wdata_i(acc_wdata_i), .acc_ack_o(acc_ack_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .hold_o(hold_o), .err_o(err_o)
  );

  typedef struct {
    logic idv; logic [4:0] r1, r2; logic we; logic [4:0] wa; logic lng, unit, jmp;
    logic exwe; logic [4:0] exwa; logic [31:0] exwd;
    logic dv; logic [31:0] dd; logic av; logic [31:0] ad;
    logic e_we; logic [4:0] e_wa; logic [31:0] e_wd; logic e_dack, e_aack, e_hold, e_err;
  } vec_t;

  function automatic vec_t mk(input logic idv, input logic [4:0] r1, r2, input logic we,
      input logic [4:0] wa, input logic lng, unit, jmp, input logic exwe, input logic [4:0] exwa,
      input logic [31:0] exwd, input logic dv, input logic [31:0] dd, input logic av,
      input logic [31:0] ad, input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
      input logic e_dack, e_aack, e_hold, e_err);
    vec_t t;
    t.idv = idv; t.r1 = r1; t.r2 = r2; t.we = we; t.wa = wa; t.lng = lng; t.unit = unit;
    t.jmp = jmp; t.exwe = exwe; t.exwa = exwa; t.exwd = exwd; t.dv = dv; t.dd = dd;
    t.av = av; t.ad = ad; t.e_we = e_we; t.e_wa = e_wa; t.e_wd = e_wd; t.e_dack = e_dack;
    t.e_aack = e_aack; t.e_hold = e_hold; t.e_err = e_err;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid_i = t.idv; id_reg1_raddr_i = t.r1; id_reg2_raddr_i = t.r2; id_reg_we_i = t.we;
    id_reg_waddr_i = t.wa; id_long_i = t.lng; id_long_unit_i = t.unit; ex_jump_flag_i = t.jmp;
    ex_we_i = t.exwe; ex_waddr_i = t.exwa; ex_wdata_i = t.exwd;
    div_valid_i = t.dv; div_wdata_i = t.dd; acc_valid_i = t.av; acc_wdata_i = t.ad;
  endtask

  task automatic chk_all(input string tag, input logic we, input logic [4:0] wa,
      input logic [31:0] wd, input logic dack, aack, hold, err);
    chk({tag, ".reg_we"}, 32'(reg_we_o), 32'(we));
    chk({tag, ".reg_waddr"}, 32'(reg_waddr_o), 32'(wa));
    chk({tag, ".reg_wdata"}, reg_wdata_o, wd);
    chk({tag, ".div_ack"}, 32'(div_ack_o), 32'(dack));
    chk({tag, ".acc_ack"}, 32'(acc_ack_o), 32'(aack));
    chk({tag, ".hold"}, 32'(hold_o), 32'(hold));
    chk({tag, ".err"}, 32'(err_o), 32'(err));
  endtask

  vec_t tbl[$];
  vec_t idle;
  int n;
  bit seen;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    // round-robin from reset: divider wins first
    tbl.push_back(mk(1,0,0,1,10,1,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,11,1,1,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0, 1,32'hA,1,32'hB, 1,10,32'hA,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0, 0,0,1,32'hB, 1,11,32'hB,0,1,0,0));
    // divider hazard on x5
    tbl.push_back(mk(1,1,2,1,5,1,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,5,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,5,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,1,5,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,5,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,5,0,0,0,0,0,0, 0,0,0, 1,7,0,0, 1,5,7,1,0,1,0));
    tbl.push_back(mk(1,5,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    // execute priority over a ready divider
    tbl.push_back(mk(1,0,0,1,9,1,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,3,32'h33, 1,32'h99,0,0, 1,3,32'h33,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0, 1,32'h99,0,0, 1,9,32'h99,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0,32'hDEAD, 0,0,0,0, 0,0,0,0,0,0,0));
    // accelerator to x0: tracked, structural hazard, no hazard compare, no write
    tbl.push_back(mk(1,0,0,1,0,1,1,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,12,1,1,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,1,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0, 0,0,1,32'h55, 0,0,32'h55,0,1,0,0));
    // killed issue leaves an orphan divider result
    tbl.push_back(mk(1,0,0,1,6,1,0,1, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,6,0,0,0,0,0,0, 0,0,0, 1,32'h77,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,1));
    tbl.push_back(mk(1,6,0,0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,1));

    rst = 1'b0;
    apply(idle);
    #12 chk_all("reset", 0,0,0,0,0,0,0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_wa, tbl[i].e_wd,
              tbl[i].e_dack, tbl[i].e_aack, tbl[i].e_hold, tbl[i].e_err);
      @(posedge clk) #1;
    end

    // mid-operation reset discards the pending x8 entry
    apply(mk(1,0,0,1,8,1,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk) chk("rst_issue.hold", 32'(hold_o), 0);
    @(posedge clk) #1;
    apply(mk(1,8,0,0,0,0,0,0, 1,3,32'h1, 0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    chk("rst_pre.hold", 32'(hold_o), 1);
    chk("rst_pre.reg_we", 32'(reg_we_o), 1);
    #1 rst = 1'b0;
    #1 chk_all("rst_mid", 0,0,0,0,0,0,0);
    @(negedge clk) rst = 1'b1;
    ex_we_i = 1'b0;
    #1 chk_all("rst_after", 0,0,0,0,0,0,0);
    @(posedge clk) #1;

    // starvation: execute writes x7 every cycle while the divider waits
    apply(mk(1,0,0,1,13,1,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    @(posedge clk) #1;
    apply(mk(0,0,0,0,0,0,0,0, 1,7,32'h70, 1,32'hD0,0,0, 0,0,0,0,0,0,0));
    seen = 1'b0;
    n = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      chk($sformatf("starve%0d.div_ack", c), 32'(div_ack_o), 0);
      chk($sformatf("starve%0d.reg_waddr", c), 32'(reg_waddr_o), 7);
      if (hold_o) begin seen = 1'b1; n = c; end
      @(posedge clk) #1;
    end
    chk("starve.hold_cycle", 32'(n), 5);
    ex_we_i = 1'b0;
    @(negedge clk) chk_all("starve_bubble", 1,13,32'hD0,1,0,1,0);
    @(posedge clk) #1;
    div_valid_i = 1'b0;
    @(negedge clk) chk("starve_release.hold", 32'(hold_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
